// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a terminal HALT state.
// Optional zero/carry status flags are built only when MC_DATAPATH_FLAGS_EN is defined.
module mc_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mem_data,
    input  logic                  mem_valid,
    output logic                  fetch_req,
    output logic [2:0]            state,
    output logic [31:0]           instr,
    output logic                  wb_valid,
    output logic [4:0]            wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  halted,
    output logic                  illegal,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [31:0]           r_instr;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_opA;
    logic [DATA_WIDTH-1:0] r_opB;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_illegal;

    logic [5:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_funct;
    logic                  w_isAlu;
    logic                  w_isLoadi;
    logic                  w_isHalt;
    logic [DATA_WIDTH-1:0] w_rs1Val;
    logic [DATA_WIDTH-1:0] w_rs2Val;
    logic [DATA_WIDTH-1:0] w_shamt;
    logic [DATA_WIDTH-1:0] w_aluResult;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_opcode  = r_instr[31:26];
    assign w_rd      = r_instr[25:21];
    assign w_rs1     = r_instr[20:16];
    assign w_rs2     = r_instr[15:11];
    assign w_funct   = r_instr[4:0];
    assign w_isAlu   = (w_opcode == 6'h00) && (w_funct[4:3] == 2'b00);
    assign w_isLoadi = (w_opcode == 6'h01);
    assign w_isHalt  = (w_opcode == 6'h3F);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH:     if (mem_valid) w_nextState = S_DECODE;
            S_DECODE: begin
                if (w_isHalt)                    w_nextState = S_HALT;
                else if (w_isAlu || w_isLoadi)   w_nextState = S_EXECUTE;
                else                             w_nextState = S_FETCH;
            end
            S_EXECUTE:   w_nextState = S_WRITEBACK;
            S_WRITEBACK: w_nextState = S_FETCH;
            S_HALT:      w_nextState = S_HALT;
            default:     w_nextState = S_FETCH;
        endcase
    end

    // Register 0 and out-of-range addresses never match a stored entry, so they read as zero.
    always_comb begin
        w_rs1Val = '0;
        w_rs2Val = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_rs1 == 5'(i)) w_rs1Val = r_regs[i];
            if (w_rs2 == 5'(i)) w_rs2Val = r_regs[i];
        end
    end

`ifdef MC_DATAPATH_FLAGS_EN
    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_diff;
    assign w_sum  = {1'b0, r_opA} + {1'b0, r_opB};
    assign w_diff = {1'b0, r_opA} - {1'b0, r_opB};
`else
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    assign w_sum  = r_opA + r_opB;
    assign w_diff = r_opA - r_opB;
`endif

    assign w_shamt = DATA_WIDTH'(r_opB % DATA_WIDTH);

    always_comb begin
        w_aluResult = '0;
        case (w_funct[2:0])
            3'd0: w_aluResult = w_sum[DATA_WIDTH-1:0];
            3'd1: w_aluResult = w_diff[DATA_WIDTH-1:0];
            3'd2: w_aluResult = r_opA & r_opB;
            3'd3: w_aluResult = r_opA | r_opB;
            3'd4: w_aluResult = r_opA ^ r_opB;
            3'd5: w_aluResult = r_opA << w_shamt;
            3'd6: w_aluResult = r_opA >> w_shamt;
            3'd7: w_aluResult = {{(DATA_WIDTH-1){1'b0}}, (r_opA < r_opB)};
            default: w_aluResult = '0;
        endcase
    end

    assign w_result = w_isLoadi ? DATA_WIDTH'(r_instr[15:0]) : w_aluResult;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr   <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (r_state == S_DECODE) && !w_isHalt && !w_isAlu && !w_isLoadi;
            if (r_state == S_FETCH && mem_valid) r_instr <= mem_data;
            if (r_state == S_DECODE) begin
                r_opA <= w_rs1Val;
                r_opB <= w_rs2Val;
            end
            if (r_state == S_EXECUTE) r_result <= w_result;
        end
    end

    // Writes to r0 or beyond NUM_REGS match no entry and are silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (r_state == S_WRITEBACK) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_rd == 5'(i)) r_regs[i] <= r_result;
            end
        end
    end

`ifdef MC_DATAPATH_FLAGS_EN
    logic r_carryRes;
    logic r_zero;
    logic r_carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carryRes <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            if (r_state == S_EXECUTE) begin
                r_carryRes <= (w_funct[2:0] == 3'd0) ? w_sum[DATA_WIDTH] :
                              (w_funct[2:0] == 3'd1) ? w_diff[DATA_WIDTH] : 1'b0;
            end
            if (r_state == S_WRITEBACK && w_opcode == 6'h00) begin
                r_zero  <= (r_result == '0);
                r_carry <= r_carryRes;
            end
        end
    end

    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
`else
    assign zero_flag  = 1'b0;
    assign carry_flag = 1'b0;
`endif

    assign state     = r_state;
    assign fetch_req = (r_state == S_FETCH);
    assign instr     = r_instr;
    assign wb_valid  = (r_state == S_WRITEBACK);
    assign wb_addr   = w_rd;
    assign wb_data   = r_result;
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath (DATA_WIDTH=16, NUM_REGS=8): directed table,
// randomized instructions against an architectural model, and reset/halt sequences.
module tb_mc_datapath;

    logic        clk;
    logic        reset;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        fetch_req;
    logic [2:0]  state;
    logic [31:0] instr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        halted;
    logic        illegal;
    logic        zero_flag;
    logic        carry_flag;

    int vectors;
    int miscompares;

`ifdef MC_DATAPATH_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // Architectural model: plain register contents and flag values.
    int mRegs [32];
    bit mZero;
    bit mCarry;

    // Values seen on the write-back port during the last instruction.
    bit          gotWb;
    logic [4:0]  gotAddr;
    logic [15:0] gotData;

    mc_datapath #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .mem_data(mem_data), .mem_valid(mem_valid),
        .fetch_req(fetch_req), .state(state), .instr(instr), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted), .illegal(illegal),
        .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int readReg(input int a);
        return (a == 0 || a >= 8) ? 0 : mRegs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 0;
        mZero  = 1'b0;
        mCarry = 1'b0;
    endtask

    // Called on a falling edge with the DUT in FETCH; returns on the falling edge after the fetch.
    task automatic applyStimulus(input logic [31:0] ins);
        checkOutput("fetchReady", {31'b0, fetch_req}, 32'd1);
        mem_data  = ins;
        mem_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        mem_data  = $urandom;
    endtask

    task automatic runInstr(input logic [31:0] ins);
        int op, rd, rs1, rs2, fn, a, b, res, kind;
        bit car;
        op  = int'(ins[31:26]);
        rd  = int'(ins[25:21]);
        rs1 = int'(ins[20:16]);
        rs2 = int'(ins[15:11]);
        fn  = int'(ins[4:0]);
        a   = readReg(rs1);
        b   = readReg(rs2);
        res = 0;
        car = 1'b0;
        if (op == 'h3F) kind = 2;
        else if (op == 1) begin kind = 0; res = int'(ins[15:0]); end
        else if (op == 0 && fn < 8) begin
            kind = 0;
            case (fn)
                0: begin res = a + b; car = (res > 'hFFFF); end
                1: begin res = a - b; car = (a < b); end
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
                5: res = a << (b % 16);
                6: res = a >> (b % 16);
                default: res = (a < b) ? 1 : 0;
            endcase
            res = res & 'hFFFF;
        end else kind = 1;

        gotWb   = 1'b0;
        gotAddr = '0;
        gotData = '0;
        applyStimulus(ins);
        checkOutput("decodeState", {29'b0, state}, 32'd1);
        checkOutput("instrLoaded", instr, ins);
        @(negedge clk);
        gotWb = wb_valid;
        if (kind == 2) begin
            checkOutput("haltState", {29'b0, state}, 32'd4);
            checkOutput("halted", {31'b0, halted}, 32'd1);
            checkOutput("haltFetchReq", {31'b0, fetch_req}, 32'd0);
        end else if (kind == 1) begin
            checkOutput("illegalState", {29'b0, state}, 32'd0);
            checkOutput("illegalPulse", {31'b0, illegal}, 32'd1);
            @(negedge clk);
            gotWb = gotWb | wb_valid;
            checkOutput("illegalDrop", {31'b0, illegal}, 32'd0);
            checkOutput("illegalNoWb", {31'b0, gotWb}, 32'd0);
        end else begin
            checkOutput("execState", {29'b0, state}, 32'd2);
            @(negedge clk);
            gotWb   = gotWb | wb_valid;
            gotAddr = wb_addr;
            gotData = wb_data;
            checkOutput("wbValid", {31'b0, wb_valid}, 32'd1);
            checkOutput("wbAddr", {27'b0, wb_addr}, rd);
            checkOutput("wbData", {16'b0, wb_data}, res);
            if (rd != 0 && rd < 8) mRegs[rd] = res;
            if (op == 0) begin
                mZero  = (res == 0);
                mCarry = car;
            end
            @(negedge clk);
            checkOutput("backToFetch", {29'b0, state}, 32'd0);
            checkOutput("wbDrop", {31'b0, wb_valid}, 32'd0);
            checkOutput("zeroFlag", {31'b0, zero_flag}, FLAGS ? {31'b0, mZero} : 32'd0);
            checkOutput("carryFlag", {31'b0, carry_flag}, FLAGS ? {31'b0, mCarry} : 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        bit          expWb;
        logic [4:0]  expAddr;
        logic [15:0] expData;
    } vec_t;

    vec_t table_v [9];

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelReset();

        table_v[0] = '{32'h04200014, 1'b1, 5'd1, 16'd20};
        table_v[1] = '{32'h04400016, 1'b1, 5'd2, 16'd22};
        table_v[2] = '{32'h00611000, 1'b1, 5'd3, 16'd42};
        table_v[3] = '{32'h00811001, 1'b1, 5'd4, 16'hFFFE};
        table_v[4] = '{32'h08000000, 1'b0, 5'd0, 16'd0};
        table_v[5] = '{32'h0400FFFF, 1'b1, 5'd0, 16'hFFFF};
        table_v[6] = '{32'h00A00000, 1'b1, 5'd5, 16'd0};
        table_v[7] = '{32'h05200007, 1'b1, 5'd9, 16'd7};
        table_v[8] = '{32'h00C90800, 1'b1, 5'd6, 16'd20};

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rstState", {29'b0, state}, 32'd0);
        checkOutput("rstFetchReq", {31'b0, fetch_req}, 32'd1);
        checkOutput("rstInstr", instr, 32'd0);
        checkOutput("rstOutputs", {26'b0, wb_valid, halted, illegal, zero_flag, carry_flag, 1'b0}, 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("holdState", {29'b0, state}, 32'd0);
        checkOutput("holdInstr", instr, 32'd0);

        for (int i = 0; i < 9; i++) begin
            runInstr(table_v[i].ins);
            checkOutput($sformatf("tbl%0dWb", i), {31'b0, gotWb}, {31'b0, table_v[i].expWb});
            if (table_v[i].expWb) begin
                checkOutput($sformatf("tbl%0dAddr", i), {27'b0, gotAddr}, {27'b0, table_v[i].expAddr});
                checkOutput($sformatf("tbl%0dData", i), {16'b0, gotData}, {16'b0, table_v[i].expData});
            end
        end
        checkOutput("tblCarry", {31'b0, carry_flag}, 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("idleInstrKept", instr, 32'h00C90800);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins;
            int sel;
            sel = $urandom_range(0, 9);
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 9));
            ins[20:16] = 5'($urandom_range(0, 9));
            if (sel <= 5) begin
                ins[31:26] = 6'h00;
                ins[15:11] = 5'($urandom_range(0, 9));
                ins[4:0]   = 5'($urandom_range(0, 7));
            end else if (sel <= 7) begin
                ins[31:26] = 6'h01;
            end else if (sel == 8) begin
                ins[31:26] = 6'($urandom_range(2, 62));
            end else begin
                ins[31:26] = 6'h00;
                ins[4:0]   = 5'($urandom_range(8, 31));
            end
            runInstr(ins);
        end

        runInstr(32'hFC000000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("haltStays", {29'b0, state}, 32'd4);
            checkOutput("haltNoWb", {31'b0, wb_valid}, 32'd0);
        end

        #2 reset = 1'b1;
        #1 checkOutput("rstInHalt", {29'b0, state}, 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        runInstr(32'h04601234);
        runInstr(32'h00831000);

        applyStimulus(32'h04605555);
        @(negedge clk);
        checkOutput("preRstExec", {29'b0, state}, 32'd2);
        #1 reset = 1'b1;
        #1 checkOutput("rstInExec", {29'b0, state}, 32'd0);
        checkOutput("rstExecNoWb", {31'b0, wb_valid}, 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postRstState", {29'b0, state}, 32'd0);
        runInstr(32'h00830000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
